// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with an input FIFO.
// Character width DATA_BITS (5..9, LSB first), optional even/odd parity,
// one or two stop bits, bit timing from an external clken pulse.
// Optional feature macro: UART_TX_BREAK_EN adds the send_break input.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    input  logic                 clken,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BP_W  = $clog2(DATA_BITS);
    localparam logic [BP_W-1:0]  LAST  = BP_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULLC = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr, r_rptr;
    logic [CNT_W-1:0]       r_count, w_cnt_nxt;
    logic                   r_full, r_empty, r_ovf;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [BP_W-1:0]        r_bitpos;
    logic                   r_par_en, r_par_odd, r_two_stop;
    logic                   r_tx, w_tx_nxt;
    logic                   r_brk;
    logic                   w_brk_in, w_push, w_pop;

`ifdef UART_TX_BREAK_EN
    assign w_brk_in = send_break;
`else
    assign w_brk_in = 1'b0;
`endif

    // A full FIFO drops the write; pops only from IDLE, held off while a break is active
    assign w_push = wr_en & ~r_full;
    assign w_pop  = (r_state == S_IDLE) & ~r_empty & ~w_brk_in & ~r_brk;

    assign tx         = r_tx;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign overflow   = r_ovf;
    assign tx_busy    = (r_state != S_IDLE) | ~r_empty | r_brk;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + 1'b1;
            2'b01:   w_cnt_nxt = r_count - 1'b1;
            default: w_cnt_nxt = r_count;
        endcase
    end

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    // FIFO pointers, count and registered flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == FULLC);
            r_empty <= (w_cnt_nxt == '0);
            r_ovf   <= wr_en & r_full;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: IDLE leaves on a pop regardless of clken, other states step on clken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_pop) w_state_nxt = S_START;
            S_START:  if (clken) w_state_nxt = S_DATA;
            S_DATA:   if (clken && r_bitpos == LAST)
                          w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (clken) w_state_nxt = S_STOP1;
            S_STOP1:  if (clken) w_state_nxt = r_two_stop ? S_STOP2 : S_IDLE;
            S_STOP2:  if (clken) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output: next line level; holds unless a transition drives it
    always_comb begin
        w_tx_nxt = r_tx;
        case (r_state)
            S_IDLE: begin
                if (w_brk_in)           w_tx_nxt = 1'b0;
                else if (r_brk && clken) w_tx_nxt = 1'b1;
            end
            S_START:  if (clken) w_tx_nxt = 1'b0;
            S_DATA:   if (clken) w_tx_nxt = r_shreg[r_bitpos];
            S_PARITY: if (clken) w_tx_nxt = (^r_shreg) ^ r_par_odd;
            S_STOP1:  if (clken) w_tx_nxt = 1'b1;
            S_STOP2:  if (clken) w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Frame datapath: load character and frame config on pop, walk bit position
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx       <= 1'b1;
            r_shreg    <= '0;
            r_bitpos   <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_tx <= w_tx_nxt;
            if (w_pop) begin
                r_shreg    <= r_mem[r_rptr];
                r_par_en   <= parity_en;
                r_par_odd  <= parity_odd;
                r_two_stop <= two_stop;
            end
            if (r_state == S_START && clken)
                r_bitpos <= '0;
            else if (r_state == S_DATA && clken && r_bitpos != LAST)
                r_bitpos <= r_bitpos + 1'b1;
            // Break latches while requested in IDLE, releases on the first clken after
            if (r_state == S_IDLE) begin
                if (w_brk_in)   r_brk <= 1'b1;
                else if (clken) r_brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed bench for uart_tx_fifo.
// A queue-level model (FIFO as a queue, each frame as a list of line levels)
// is compared against the DUT on every cycle; literal expectations pin key frames.
module tb_uart_tx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic          clock = 1'b0, reset_n = 1'b0;
    logic [DB-1:0] din = '0;
    logic          wr_en = 1'b0, clken = 1'b0;
    logic          pe = 1'b0, po = 1'b0, ts = 1'b0;
    logic          tx, tx_busy, fifo_full, fifo_empty, overflow;

    uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .din(din), .wr_en(wr_en), .clken(clken),
        .parity_en(pe), .parity_odd(po), .two_stop(ts),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .overflow(overflow)
    );

    initial forever #5 clock = ~clock;

    int checks = 0, errors = 0;
    int ck_per = 4;
    int ovf_cnt = 0;
    bit chk_on = 1'b0;

    // model state
    int mq[$];
    bit lv[$];
    bit m_act = 1'b0, m_tx = 1'b1, m_ovf = 1'b0, m_emit = 1'b0;
    int m_ckn = 0;
    bit e0, f0;
    int md;

    // emitted line levels (DUT values) and the clken index at which each was emitted
    bit txlog[$];
    int tidx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: FIFO queue plus list of remaining levels of the current frame
    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            mq.delete(); lv.delete();
            m_act = 1'b0; m_tx = 1'b1; m_ovf = 1'b0; m_emit = 1'b0;
        end else begin
            e0 = (mq.size() == 0);
            f0 = (mq.size() == DEPTH);
            m_emit = 1'b0;
            m_ovf = wr_en && f0;
            if (clken) m_ckn++;
            if (m_act) begin
                if (clken) begin
                    m_tx = lv.pop_front();
                    m_emit = 1'b1;
                    if (lv.size() == 0) m_act = 1'b0;
                end
            end else if (!e0) begin
                md = mq.pop_front();
                lv.delete();
                lv.push_back(1'b0);
                for (int i = 0; i < DB; i++) lv.push_back(md[i]);
                if (pe) lv.push_back((^md[DB-1:0]) ^ po);
                lv.push_back(1'b1);
                if (ts) lv.push_back(1'b1);
                m_act = 1'b1;
            end
            if (wr_en && !f0) mq.push_back(int'(din));
        end
    end

    // per-cycle compare, away from the active edge
    initial forever begin
        @(negedge clock);
        if (chk_on) begin
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_act || mq.size() != 0);
            chk("fifo_full", fifo_full, mq.size() == DEPTH);
            chk("fifo_empty", fifo_empty, mq.size() == 0);
            chk("overflow", overflow, m_ovf);
            if (overflow) ovf_cnt++;
            if (m_emit) begin
                txlog.push_back(tx);
                tidx.push_back(m_ckn);
            end
        end
    end

    // bit-period enable: one pulse every ck_per cycles
    initial begin
        int c = 0;
        forever begin
            @(posedge clock); #1;
            if (c + 1 >= ck_per) begin clken = 1'b1; c = 0; end
            else begin clken = 1'b0; c++; end
        end
    end

    task automatic put(input logic [DB-1:0] d);
        @(posedge clock); #1;
        din = d; wr_en = 1'b1;
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_log(input string nm, input int n, input int budget);
        int k = 0;
        while (txlog.size() < n && k < budget) begin @(negedge clock); k++; end
        chk(nm, txlog.size() >= n, 1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        @(negedge clock);
        while (tx_busy && k < budget) begin @(negedge clock); k++; end
        chk(nm, tx_busy, 1'b0);
    endtask

    task automatic clr_log();
        txlog.delete(); tidx.delete();
    endtask

    function automatic int frame_data(input int base);
        int v = 0;
        for (int i = 0; i < DB; i++) v |= int'(txlog[base + 1 + i]) << i;
        return v;
    endfunction

    logic [9:0] seq;
    logic [DB-1:0] vals [6] = '{8'h31, 8'hC4, 8'h5E, 8'h09, 8'hF0, 8'h77};

    initial begin
        // reset then 100 idle clken periods
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        chk_on = 1'b1;
        ck_per = 4;
        repeat (400) @(posedge clock);
        @(negedge clock);
        chk("idle_tx", tx, 1'b1);
        chk("idle_empty", fifo_empty, 1'b1);
        chk("idle_busy", tx_busy, 1'b0);

        // 8N1 0xA5
        clr_log();
        @(posedge clock); #1 din = 8'hA5; wr_en = 1'b1;
        @(posedge clock); #1 wr_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("a5_empty_after_pop", fifo_empty, 1'b1);
        wait_log("a5_log", 10, 400);
        for (int i = 0; i < 10; i++) seq[i] = txlog[i];
        chk("a5_seq", seq, 10'h34A);
        chk("a5_span", tidx[9] - tidx[0], 9);
        wait_idle("a5_idle", 50);

        // even parity on 0x07, parity_odd toggled mid-frame
        clr_log();
        pe = 1'b1; po = 1'b0;
        put(8'h07);
        wait_log("pe_start", 2, 200);
        po = 1'b1;
        wait_log("pe_log", 11, 400);
        chk("par_even", txlog[9], 1'b1);
        chk("par_even_stop", txlog[10], 1'b1);
        wait_idle("pe_idle", 50);
        clr_log();
        put(8'h07);
        wait_log("po_start", 2, 200);
        po = 1'b0;
        wait_log("po_log", 11, 400);
        chk("par_odd", txlog[9], 1'b0);
        wait_idle("po_idle", 50);
        pe = 1'b0;

        // two stop bits, back-to-back 0x00 / 0xFF
        clr_log();
        ts = 1'b1;
        put(8'h00);
        put(8'hFF);
        wait_log("ts_log", 22, 800);
        chk("ts_last_data", txlog[8], 1'b0);
        chk("ts_stop1", txlog[9], 1'b1);
        chk("ts_stop2", txlog[10], 1'b1);
        chk("ts_start2", txlog[11], 1'b0);
        chk("ts_gap", tidx[11] - tidx[8], 3);
        chk("ts_data2", frame_data(11), 8'hFF);
        wait_idle("ts_idle", 50);
        ts = 1'b0;

        // overflow: 6 consecutive writes, first pops immediately
        clr_log();
        ck_per = 3;
        ovf_cnt = 0;
        @(posedge clock); #1;
        for (int i = 0; i < 6; i++) begin
            din = vals[i]; wr_en = 1'b1;
            @(posedge clock); #1;
        end
        wr_en = 1'b0;
        @(negedge clock);
        chk("ovf_full", fifo_full, 1'b1);
        repeat (4) @(negedge clock);
        chk("ovf_pulses", ovf_cnt, 1);
        wait_log("ovf_log", 50, 3000);
        for (int f = 0; f < 5; f++) chk("ovf_order", frame_data(f * 10), vals[f]);
        wait_idle("ovf_idle", 100);

        // reset mid-DATA with a queued character
        clr_log();
        ck_per = 4;
        put(8'h3C);
        put(8'h81);
        wait_log("rst_mid", 4, 400);
        chk("rst_pre_empty", fifo_empty, 1'b0);
        @(posedge clock); #3 reset_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        clr_log();
        repeat (5) @(negedge clock);
        chk("rst_discard", tx_busy, 1'b0);
        put(8'h5A);
        wait_log("rst_log", 10, 400);
        chk("rst_start", txlog[0], 1'b0);
        chk("rst_data", frame_data(0), 8'h5A);
        chk("rst_stop", txlog[9], 1'b1);
        wait_idle("rst_idle", 50);

        // randomized traffic, clken rate and frame config
        for (int b = 0; b < 40; b++) begin
            ck_per = $urandom_range(1, 5);
            repeat (50) begin
                @(posedge clock); #1;
                wr_en = ($urandom_range(0, 3) == 0);
                din   = DB'($urandom);
                pe    = 1'($urandom_range(0, 1));
                po    = 1'($urandom_range(0, 1));
                ts    = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clock); #1 wr_en = 1'b0;
        ck_per = 2;
        wait_idle("rand_drain", 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
